// File: rtl/ahblite_cmd_master_if.sv
// ahblite_cmd_master_if
//   Bundles the command/response handshake and the AHB-Lite initiator bus of
//   ahblite_cmd_master.
//   master modport : the command master itself (accepts commands, drives
//                    responses, drives the AHB address/control/write data).
//   slave modport  : the other side (command source, response sink and AHB
//                    slave / interconnect).
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/cmd_wdata : request
//     rsp_valid/rsp_rdata/rsp_err                                : response
//     HADDR/HBURST/HMASTLOCK/HPROT/HSIZE/HTRANS/HWDATA/HWRITE    : AHB out
//     HREADY/HRDATA/HRESP                                        : AHB in
interface ahblite_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_cmd_master.sv
// ahblite_cmd_master
//   Turns single-beat command requests into AHB-Lite SINGLE transfers with a
//   two-slot pipeline: slot A is the transfer in its address phase, slot D the
//   transfer in its data phase. One response pulse is produced per accepted
//   command, in order. A bus error seen while a second transfer sits in the
//   address phase cancels that transfer; it is answered with an error
//   response right after the failing one.
//   Ports:
//     HCLK    : clock, rising edge
//     HRESET  : synchronous active-high reset
//     bus     : ahblite_cmd_master_if.master (command, response, AHB-Lite)
//     err_addr, err_cnt : present only with AHBM_ERR_CAPTURE_EN defined;
//                         address of the last erroring transfer and a
//                         saturating error count.
//   Build option: define AHBM_ERR_CAPTURE_EN to add the error capture outputs.
module ahblite_cmd_master (
  input  logic        HCLK,
  input  logic        HRESET,
`ifdef AHBM_ERR_CAPTURE_EN
  output logic [31:0] err_addr,
  output logic [7:0]  err_cnt,
`endif
  ahblite_cmd_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD     = 3'b010;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slot_t;

  slot_t       a_q, a_d;
  slot_t       d_q, d_d;
  slot_t       new_slot;
  logic        cancel_pending_q, cancel_pending_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        cmd_ready;
  logic        cmd_accept;
  logic        d_done;
  logic        err_first;
  logic        unused_d_fields;

  // A can take a new command when empty, or when it is leaving this cycle
  // without an error pending against the transfer ahead of it.
  assign cmd_ready  = !HRESET && !cancel_pending_q &&
                      (!a_q.valid || (bus.HREADY && !bus.HRESP));
  assign cmd_accept = bus.cmd_valid && cmd_ready;
  assign d_done     = d_q.valid && bus.HREADY;
  // First cycle of a two-cycle error response with a transfer queued behind.
  assign err_first  = d_q.valid && bus.HRESP && !bus.HREADY && a_q.valid;

  always_comb begin
    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.write = bus.cmd_write;
    new_slot.size  = (bus.cmd_size > SIZE_WORD) ? SIZE_WORD : bus.cmd_size;
    new_slot.addr  = bus.cmd_addr;
    new_slot.wdata = bus.cmd_wdata;
  end

  always_comb begin
    a_d              = a_q;
    d_d              = d_q;
    cancel_pending_d = cancel_pending_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = '0;
    rsp_err_d        = 1'b0;

    if (bus.HREADY) begin
      d_d       = a_q.valid ? a_q : '0;
      a_d.valid = 1'b0;
      if (cmd_accept) a_d = new_slot;
    end else if (err_first) begin
      // Dropping to IDLE while HREADY is low is the one permitted change
      // of address-phase signals during a wait.
      a_d.valid        = 1'b0;
      cancel_pending_d = 1'b1;
    end else if (cmd_accept) begin
      // Only reachable with A empty: IDLE -> NONSEQ during a wait state.
      a_d = new_slot;
    end

    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = bus.HRESP;
      rsp_rdata_d = d_q.write ? '0 : bus.HRDATA;
    end else if (cancel_pending_q && !d_q.valid) begin
      // The erroring transfer answered last cycle; now answer the one that
      // never reached its data phase.
      rsp_valid_d      = 1'b1;
      rsp_err_d        = 1'b1;
      cancel_pending_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_q              <= '0;
      d_q              <= '0;
      cancel_pending_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
    end else begin
      a_q              <= a_d;
      d_q              <= d_d;
      cancel_pending_q <= cancel_pending_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = 4'b0011;
  assign bus.HTRANS    = a_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_q.addr;
  assign bus.HWRITE    = a_q.write;
  assign bus.HSIZE     = a_q.size;
  assign bus.HWDATA    = d_q.valid ? d_q.wdata : '0;

  // D keeps the full transfer description even where only part is consumed.
  assign unused_d_fields = ^{d_q.size, d_q.addr};

`ifdef AHBM_ERR_CAPTURE_EN
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (d_done && bus.HRESP) begin
      err_addr_d = d_q.addr;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: doc/ahblite_cmd_master.md
AHBLITE_CMD_MASTER -- requirements
Module: ahblite_cmd_master

Interface
REQ-001 SHALL have ports: HCLK  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: HRESET  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 32, cmd_size in 3, cmd_wdata in 32; one single-beat transfer request.
REQ-004 SHALL have ports: rsp_valid out 1 (1-cycle pulse), rsp_rdata out 32, rsp_err out 1; no back-pressure.
REQ-005 SHALL have AHB-Lite initiator ports: HADDR out 32, HBURST out 3, HMASTLOCK out 1, HPROT out 4, HSIZE out 3, HTRANS out 2, HWDATA out 32, HWRITE out 1, HREADY in 1, HRDATA in 32, HRESP in 1.

Function
REQ-006 SHALL keep HBURST=3'b000 (SINGLE), HMASTLOCK=0, HPROT=4'b0011 constant.
REQ-007 SHALL hold an address-phase slot A and a data-phase slot D, each valid flag plus addr/write/size/wdata.
REQ-008 SHALL drive HTRANS=2'b10 (NONSEQ) when A valid, else 2'b00 (IDLE); HADDR/HWRITE/HSIZE from A.
REQ-009 SHALL drive HWDATA from D.wdata; 0 when D empty.
REQ-010 SHALL assert cmd_ready = !HRESET && !cancel_pending && (!A.valid || (HREADY && !HRESP)).
REQ-011 SHALL, on HREADY=1 at an edge, move A into D (D cleared if A empty), then load A from an accepted command.
REQ-012 SHALL, on HREADY=0, hold A, D and all address/control/HWDATA outputs stable; an empty A may be loaded (IDLE->NONSEQ) during a wait state.
REQ-013 SHALL clamp cmd_size above 3'b010 to 3'b010; HADDR passed unmodified.
REQ-014 Latency: handshake at edge ending cycle k -> NONSEQ in k+1 -> data phase k+2 -> rsp_valid in k+3 with zero-wait slave.
REQ-015 SHALL sustain one transfer per cycle back-to-back with zero-wait slaves.
REQ-016 SHALL, when D completes (D.valid, HREADY=1), assert rsp_valid next cycle with rsp_rdata=HRDATA (reads; 0 for writes) and rsp_err=HRESP.
REQ-017 SHALL, on first error cycle (D.valid, HRESP=1, HREADY=0) with A valid, cancel A: HTRANS=IDLE next cycle, set cancel_pending.
REQ-018 SHALL report a cancelled command as rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after the erroring D response; clear cancel_pending then.
REQ-019 SHALL emit exactly one response per accepted command, in acceptance order.
REQ-020 SHALL treat rsp_rdata/rsp_err as don't-care when rsp_valid=0 but drive them 0.

Reset
REQ-021 SHALL, with HRESET=1 at an edge, clear A, D, cancel_pending, rsp_valid, rsp_err, rsp_rdata; HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0.
REQ-022 SHALL force cmd_ready=0 while HRESET=1.
REQ-023 SHALL discard outstanding transfers on reset mid-operation with no response generated.

Configuration
REQ-024 Macro AHBM_ERR_CAPTURE_EN defined: SHALL add outputs err_addr (32) and err_cnt (8); on each bus error response err_addr latches D.addr, err_cnt increments saturating at 8'hFF; both reset to 0.
REQ-025 Macro undefined: SHALL omit err_addr/err_cnt ports and logic; all other behaviour identical.

Verification
REQ-026 Single read: cmd addr 0x2000_0010, size 2, zero-wait, HRDATA=0xDEADBEEF -> NONSEQ at k+1, rsp_valid at k+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-027 Back-to-back writes to 0x40000000/04/08, data 0x11/0x22/0x33, zero-wait -> NONSEQ three consecutive cycles, HWDATA 0x11,0x22,0x33 one cycle later, three rsp pulses.
REQ-028 Write 0x40000000 with 2 wait states (HREADY=0 x2) and queued read -> HADDR/HTRANS/HWDATA stable during waits; cmd_ready=0 while A full and HREADY=0.
REQ-029 Error: write 0x50000000 followed by read 0x50000004; slave HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS IDLE next cycle, rsp_err=1 for write then rsp_err=1, rsp_rdata=0 for cancelled read; (AHBM_ERR_CAPTURE_EN) err_addr=0x50000000, err_cnt=1.
REQ-030 Reset asserted during a waited read -> HTRANS=IDLE, rsp_valid=0, cmd_ready=0 next cycle; no response after release.
